xgmii_rx_deframer: RTL
======================

// Module: xgmii_rx_deframer
// PURPOSE
// - RX front end of the 10G MAC: converts the 64-bit XGMII receive stream into the MAC packet interface.
// - Validates the start word, strips preamble/SFD, locates terminate, marks sop/eop/mod, flags errors.
// - Sits between the XGMII PHY interface and the RX MAC core. No backpressure exists on either side.
// PARAMETERS
// - MAX_FRAME_BYTES  1518  longest accepted frame (DA..FCS); longer frames are truncated with error
// PORTS
// - clk_xgmii_rx    in   1   156.25 MHz XGMII RX clock; the only clock
// - reset_xgmii_rx  in   1   synchronous, active-high reset
// - xgmii_rxd       in   64  XGMII data; lane i = bits [8i+7:8i]; lane 0 is first on the wire
// - xgmii_rxc       in   8   XGMII control; bit i set = lane i is a control character
// - pkt_rx_data     out  64  frame data, lane 0 = first byte
// - pkt_rx_val      out  1   pkt_rx_* valid this cycle (single-cycle qualifier)
// - pkt_rx_sop      out  1   first word of frame
// - pkt_rx_eop      out  1   last word of frame
// - pkt_rx_mod      out  3   valid bytes in eop word mod 8 (0 = all 8); 0 when !eop
// - pkt_rx_err      out  1   frame bad; valid only with eop
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, hold register empty, word counter 0. Reset mid-frame discards the frame silently.
// - States: IDLE, DATA, DROP.
// - IDLE: rxc==8'h01 && rxd==64'hD555_5555_5555_55FB -> DATA (start word, no output, sets sop_pending).
//   Start in lane 4 (rxc[4] && rxd[39:32]==8'hFB) or start with bad preamble/SFD -> drop event, stay IDLE.
// - DATA, rxc==0: previous held word goes out (sop if sop_pending), current word loaded to hold; word count++.
// - DATA, control present: k = lowest lane with rxc[k]=1.
//   byte k==8'hFD, k==0: held word out with eop, mod=0 -> IDLE. No held word -> drop event, no output.
//   byte k==8'hFD, k>0: held word (if any) out, not eop; lanes 0..k-1 loaded to hold, eop_pending, mod=k -> IDLE.
//   Next edge emits that word with eop (sop too if it is the only word). IDLE decoding of the same cycle's
//   input proceeds in parallel (a start word produces no output, so no collision).
//   any other control byte (incl. 8'hFE): held word out with eop, err=1, mod=0 -> DROP; no held word -> drop event -> DROP.
// - Length: word count exceeds ceil(MAX_FRAME_BYTES/8) -> held word out with eop, err=1 -> DROP.
// - DROP: discard until a word with any rxc bit set whose lowest control byte is FD or 07 -> IDLE.
// - Latency: a word sampled at edge n appears on pkt_rx_* after edge n+1; fixed for every word, including tail.
// - Output bytes beyond mod in the eop word are driven 0. Idle cycles: val=sop=eop=err=0, mod=0, data held.
// CONFIGURATION
// - Macro XGMII_RX_STATS_EN: defined -> adds outputs stat_rx_frames, stat_rx_err_frames, stat_rx_drops
//   (32 bits each, saturating, reset to 0): frames with eop&&!err, eop&&err, drop events.
//   Undefined -> ports and counters absent; all other behaviour identical.
// STRUCTURE
// - mac_pkg: XGMII_IDLE=8'h07, XGMII_START=8'hFB, XGMII_TERM=8'hFD, XGMII_ERROR=8'hFE,
//   XGMII_PREAMBLE_WORD=64'hD555_5555_5555_55FB, rx_state_t {IDLE, DATA, DROP}.
// - Sub-module xgmii_rx_lane_decode: combinational; returns first-control-lane index, its byte, any-control flag.
// TESTING
// - 64B frame: start word, 8 data words, terminate word rxc=8'hFF byte0=FD -> 8 val cycles, sop on 1st, eop+mod=0 on 8th.
// - 61B frame: 7 full words + word rxc=8'hE0, byte5=FD -> 8 val cycles, last eop mod=5, bytes 5..7 = 0.
// - Error: FE in lane 2 mid-frame -> eop with err=1 on held word, following data ignored until idle; next frame clean.
// - Lane-4 start and bad SFD (byte7=8'hD4) -> no output; stat_rx_drops=2 with XGMII_RX_STATS_EN.
// - 2000B frame with MAX_FRAME_BYTES=1518 -> eop+err after 190 words, rest dropped, next frame received intact.
// - Back-to-back: terminate lane 3 followed directly by lane-0 start -> tail eop and new start overlap correctly; reset mid-frame -> outputs 0 next cycle.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared XGMII RX definitions for the 10G MAC.
// Holds the XGMII control-character codes, the expected start word, the
// receive state type and a lane-masking helper used for tail words.
package mac_pkg;

  localparam logic [7:0]  XGMII_IDLE          = 8'h07;
  localparam logic [7:0]  XGMII_START         = 8'hFB;
  localparam logic [7:0]  XGMII_TERM          = 8'hFD;
  localparam logic [7:0]  XGMII_ERROR         = 8'hFE;
  localparam logic [63:0] XGMII_PREAMBLE_WORD = 64'hD555_5555_5555_55FB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DROP = 2'd2
  } rx_state_t;

  // Keep lanes 0..n-1 of a word and zero the rest (n = 0 keeps nothing).
  function automatic logic [63:0] keep_lanes(input logic [63:0] d, input logic [2:0] n);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < {29'd0, n}) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/xgmii_rx_lane_decode.sv
// Combinational control-lane decoder for one 64-bit XGMII word.
// Ports:
//   rxd_i      : XGMII data, lane i = bits [8i+7:8i]
//   rxc_i      : XGMII control flags, bit i = lane i is a control character
//   lane_o     : index of the lowest lane carrying a control character
//   byte_o     : the byte found in that lane
//   any_ctrl_o : at least one lane carries a control character
// lane_o/byte_o are 0 when no control lane is present.
module xgmii_rx_lane_decode (
  input  logic [63:0] rxd_i,
  input  logic [7:0]  rxc_i,
  output logic [2:0]  lane_o,
  output logic [7:0]  byte_o,
  output logic        any_ctrl_o
);

  always_comb begin
    lane_o     = '0;
    byte_o     = '0;
    any_ctrl_o = |rxc_i;
    // Scan from the top lane down so the lowest control lane is written last.
    for (int unsigned i = 8; i > 0; i--) begin
      if (rxc_i[i-1]) begin
        lane_o = 3'(i - 1);
        byte_o = rxd_i[8*(i-1) +: 8];
      end
    end
  end

endmodule

// File: rtl/xgmii_rx_deframer.sv
// XGMII RX deframer: turns the 64-bit XGMII receive stream into the MAC
// packet interface. Validates the lane-0 start word, strips preamble/SFD,
// finds the terminate character, marks sop/eop/mod and flags bad frames.
// Every data word is delayed by one hold stage so that a terminate in the
// following word can still tag it as eop; output latency is fixed.
// Ports:
//   clk_xgmii_rx   : XGMII RX clock, the only clock
//   reset_xgmii_rx : synchronous active-high reset
//   xgmii_rxd/rxc  : XGMII receive data (64) and control flags (8)
//   pkt_rx_data    : frame data, lane 0 first; bytes beyond mod zeroed on eop
//   pkt_rx_val     : pkt_rx_* valid this cycle
//   pkt_rx_sop/eop : first / last word of a frame
//   pkt_rx_mod     : valid bytes in the eop word mod 8 (0 = all 8)
//   pkt_rx_err     : frame bad, meaningful only with eop
//   stat_rx_*      : saturating frame / error-frame / drop-event counters,
//                    present only when XGMII_RX_STATS_EN is defined
// Parameter MAX_FRAME_BYTES: longest accepted frame; longer ones are cut
// with err and the remainder discarded.
module xgmii_rx_deframer
  import mac_pkg::*;
#(
  parameter int unsigned MAX_FRAME_BYTES = 1518
) (
  input  logic        clk_xgmii_rx,
  input  logic        reset_xgmii_rx,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  output logic [63:0] pkt_rx_data,
  output logic        pkt_rx_val,
  output logic        pkt_rx_sop,
  output logic        pkt_rx_eop,
  output logic [2:0]  pkt_rx_mod,
  output logic        pkt_rx_err
`ifdef XGMII_RX_STATS_EN
  ,
  output logic [31:0] stat_rx_frames,
  output logic [31:0] stat_rx_err_frames,
  output logic [31:0] stat_rx_drops
`endif
);

  localparam int unsigned MAX_WORDS = (MAX_FRAME_BYTES + 7) / 8;
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);

  // Lane decode of the incoming word
  logic [2:0] ctl_lane;
  logic [7:0] ctl_byte;
  logic       any_ctl;

  xgmii_rx_lane_decode u_lane_decode (
    .rxd_i      (xgmii_rxd),
    .rxc_i      (xgmii_rxc),
    .lane_o     (ctl_lane),
    .byte_o     (ctl_byte),
    .any_ctrl_o (any_ctl)
  );

  // State and hold stage
  rx_state_t        state_q, state_d;
  logic [63:0]      hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             sop_pend_q, sop_pend_d;
  logic             eop_pend_q, eop_pend_d;
  logic [2:0]       mod_pend_q, mod_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Output registers
  logic [63:0] data_q, data_d;
  logic        val_q, val_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [2:0]  mod_q, mod_d;
  logic        err_q, err_d;

  logic        drop_evt;
  logic        emit, emit_eop, emit_err;
  logic [2:0]  emit_mod;

  logic start_ok, start_bad;

  assign start_ok  = (xgmii_rxc == 8'h01) && (xgmii_rxd == XGMII_PREAMBLE_WORD);
  assign start_bad = (xgmii_rxc[0] && xgmii_rxd[7:0] == XGMII_START && !start_ok) ||
                     (xgmii_rxc[4] && xgmii_rxd[39:32] == XGMII_START);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sop_pend_d = sop_pend_q;
    eop_pend_d = eop_pend_q;
    mod_pend_d = mod_pend_q;
    cnt_d      = cnt_q;
    drop_evt   = 1'b0;
    emit       = 1'b0;
    emit_eop   = 1'b0;
    emit_err   = 1'b0;
    emit_mod   = '0;

    // Tail word left by a terminate in lanes 1..7 goes out now; the current
    // input is decoded as IDLE in parallel (a start word emits nothing).
    if (eop_pend_q) begin
      emit       = 1'b1;
      emit_eop   = 1'b1;
      emit_mod   = mod_pend_q;
      eop_pend_d = 1'b0;
      hold_vld_d = 1'b0;
      sop_pend_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d    = DATA;
          sop_pend_d = 1'b1;
          hold_vld_d = 1'b0;
          cnt_d      = '0;
        end else if (start_bad) begin
          drop_evt = 1'b1;
        end
      end

      DATA: begin
        if (!any_ctl) begin
          if (cnt_q == CNT_W'(MAX_WORDS)) begin
            // Over length: close the frame as bad, discard the rest.
            emit       = 1'b1;
            emit_eop   = 1'b1;
            emit_err   = 1'b1;
            sop_pend_d = 1'b0;
            hold_vld_d = 1'b0;
            state_d    = DROP;
          end else begin
            if (hold_vld_q) begin
              emit       = 1'b1;
              sop_pend_d = 1'b0;
            end
            hold_d     = xgmii_rxd;
            hold_vld_d = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end else if (ctl_byte == XGMII_TERM) begin
          if (ctl_lane == 3'd0) begin
            if (hold_vld_q) begin
              emit     = 1'b1;
              emit_eop = 1'b1;
            end else begin
              drop_evt = 1'b1;
            end
            sop_pend_d = 1'b0;
            hold_vld_d = 1'b0;
            state_d    = IDLE;
          end else if (cnt_q == CNT_W'(MAX_WORDS)) begin
            // Partial tail would push past the limit; terminate already
            // seen, so return to IDLE rather than DROP.
            emit       = 1'b1;
            emit_eop   = 1'b1;
            emit_err   = 1'b1;
            sop_pend_d = 1'b0;
            hold_vld_d = 1'b0;
            state_d    = IDLE;
          end else begin
            if (hold_vld_q) begin
              emit       = 1'b1;
              sop_pend_d = 1'b0;
            end
            hold_d     = keep_lanes(xgmii_rxd, ctl_lane);
            hold_vld_d = 1'b1;
            eop_pend_d = 1'b1;
            mod_pend_d = ctl_lane;
            cnt_d      = cnt_q + CNT_W'(1);
            state_d    = IDLE;
          end
        end else begin
          if (hold_vld_q) begin
            emit     = 1'b1;
            emit_eop = 1'b1;
            emit_err = 1'b1;
          end else begin
            drop_evt = 1'b1;
          end
          sop_pend_d = 1'b0;
          hold_vld_d = 1'b0;
          state_d    = DROP;
        end
      end

      DROP: begin
        if (any_ctl && (ctl_byte == XGMII_TERM || ctl_byte == XGMII_IDLE)) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output next-state: data holds its last value on idle cycles.
  always_comb begin
    data_d = data_q;
    val_d  = 1'b0;
    sop_d  = 1'b0;
    eop_d  = 1'b0;
    mod_d  = '0;
    err_d  = 1'b0;
    if (emit) begin
      data_d = hold_q;
      val_d  = 1'b1;
      sop_d  = sop_pend_q;
      eop_d  = emit_eop;
      mod_d  = emit_eop ? emit_mod : 3'd0;
      err_d  = emit_eop & emit_err;
    end
  end

  always_ff @(posedge clk_xgmii_rx) begin
    if (reset_xgmii_rx) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      sop_pend_q <= 1'b0;
      eop_pend_q <= 1'b0;
      mod_pend_q <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      val_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      mod_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sop_pend_q <= sop_pend_d;
      eop_pend_q <= eop_pend_d;
      mod_pend_q <= mod_pend_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      val_q      <= val_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      mod_q      <= mod_d;
      err_q      <= err_d;
    end
  end

  assign pkt_rx_data = data_q;
  assign pkt_rx_val  = val_q;
  assign pkt_rx_sop  = sop_q;
  assign pkt_rx_eop  = eop_q;
  assign pkt_rx_mod  = mod_q;
  assign pkt_rx_err  = err_q;

`ifdef XGMII_RX_STATS_EN
  logic [31:0] frames_q, err_frames_q, drops_q;

  always_ff @(posedge clk_xgmii_rx) begin
    if (reset_xgmii_rx) begin
      frames_q     <= '0;
      err_frames_q <= '0;
      drops_q      <= '0;
    end else begin
      if (val_d && eop_d && !err_d && frames_q != '1) frames_q <= frames_q + 32'd1;
      if (val_d && eop_d && err_d && err_frames_q != '1) err_frames_q <= err_frames_q + 32'd1;
      if (drop_evt && drops_q != '1) drops_q <= drops_q + 32'd1;
    end
  end

  assign stat_rx_frames     = frames_q;
  assign stat_rx_err_frames = err_frames_q;
  assign stat_rx_drops      = drops_q;
`endif

endmodule
